// File: rtl/pipe_hazard_unit.sv
// Five-stage pipeline hazard unit: tracks EX/MEM/WB destinations, raises stall/flush, EX operand forwarding and ID write-through bypass.
// Control outputs are combinational (zero latency); the saturating stall/flush counters update on the clock edge.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  rf_byp_a_o,
  output logic                  rf_byp_b_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  logic                  ex_vld, ex_rw, ex_mr, ex_use_rs, ex_use_rt;
  logic [REG_ADDR_W-1:0] ex_rd, ex_rs, ex_rt;
  logic                  mem_vld, mem_rw, mem_mr;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_vld, wb_rw;
  logic [REG_ADDR_W-1:0] wb_rd;

  // Register 0 is hardwired, so an entry targeting it never produces a dependency.
  function automatic logic writes(input logic vld, input logic rw,
                                  input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] r);
    return vld && rw && (rd == r) && (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_src,
                                         input logic [REG_ADDR_W-1:0] src);
    if (!use_src) return 2'b00;
    if (writes(mem_vld, mem_rw, mem_rd, src) && !mem_mr) return 2'b10;
    if (writes(wb_vld, wb_rw, wb_rd, src)) return 2'b01;
    return 2'b00;
  endfunction

  logic ex_hit, mem_hit, wb_hit, raw_hazard;

  always_comb begin
    ex_hit  = (id_use_rs_i && writes(ex_vld, ex_rw, ex_rd, id_rs_i)) ||
              (id_use_rt_i && writes(ex_vld, ex_rw, ex_rd, id_rt_i));
    mem_hit = (id_use_rs_i && writes(mem_vld, mem_rw, mem_rd, id_rs_i)) ||
              (id_use_rt_i && writes(mem_vld, mem_rw, mem_rd, id_rt_i));
    wb_hit  = (id_use_rs_i && writes(wb_vld, wb_rw, wb_rd, id_rs_i)) ||
              (id_use_rt_i && writes(wb_vld, wb_rw, wb_rd, id_rt_i));
    if (FWD_EN != 0) raw_hazard = ex_hit && ex_mr;
    else             raw_hazard = ex_hit || mem_hit || wb_hit;
  end

  // A taken branch squashes the stalled instruction anyway, so flush wins.
  assign flush_o    = branch_taken_i;
  assign stall_o    = id_valid_i && raw_hazard && !branch_taken_i && !rst_i;
  assign rf_byp_a_o = !rst_i && id_use_rs_i && writes(wb_vld, wb_rw, wb_rd, id_rs_i);
  assign rf_byp_b_o = !rst_i && id_use_rt_i && writes(wb_vld, wb_rw, wb_rd, id_rt_i);

  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (FWD_EN != 0 && ex_vld && !rst_i) begin
      fwd_a_o = fwd_sel(ex_use_rs, ex_rs);
      fwd_b_o = fwd_sel(ex_use_rt, ex_rt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_vld      <= 1'b0;
      mem_vld     <= 1'b0;
      wb_vld      <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      wb_vld    <= mem_vld;
      wb_rw     <= mem_rw;
      wb_rd     <= mem_rd;
      mem_vld   <= ex_vld && !branch_taken_i;
      mem_rw    <= ex_rw;
      mem_mr    <= ex_mr;
      mem_rd    <= ex_rd;
      // Payload always loads; only the valid bit marks a bubble.
      ex_vld    <= id_valid_i && !stall_o && !branch_taken_i;
      ex_rw     <= id_reg_write_i;
      ex_mr     <= id_mem_read_i;
      ex_rd     <= id_rd_i;
      ex_rs     <= id_rs_i;
      ex_rt     <= id_rt_i;
      ex_use_rs <= id_use_rs_i;
      ex_use_rt <= id_use_rt_i;
      if (stall_o && stall_cnt_o != {CNT_W{1'b1}}) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_o && flush_cnt_o != {CNT_W{1'b1}}) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: three instances (forwarding, no forwarding, 2-bit counters) driven by shared directed vectors,
// checked every cycle against an instruction-level pipeline model plus hand-computed literal expectations.
module tb_pipe_hazard_unit;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, branch;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          stall [3];
  logic          flush [3];
  logic          byp_a [3];
  logic          byp_b [3];
  logic [1:0]    fwd_a [3];
  logic [1:0]    fwd_b [3];
  logic [31:0]   scnt0, fcnt0, scnt1, fcnt1;
  logic [1:0]    scnt2, fcnt2;

  int tests = 0;
  int fails = 0;
  bit mdl_ok = 0;
  bit done = 0;

  pipe_hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(1), .CNT_W(32)) u0 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .branch_taken_i(branch),
    .stall_o(stall[0]), .flush_o(flush[0]), .fwd_a_o(fwd_a[0]), .fwd_b_o(fwd_b[0]),
    .rf_byp_a_o(byp_a[0]), .rf_byp_b_o(byp_b[0]), .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

  pipe_hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(0), .CNT_W(32)) u1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .branch_taken_i(branch),
    .stall_o(stall[1]), .flush_o(flush[1]), .fwd_a_o(fwd_a[1]), .fwd_b_o(fwd_b[1]),
    .rf_byp_a_o(byp_a[1]), .rf_byp_b_o(byp_b[1]), .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

  pipe_hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(1), .CNT_W(2)) u2 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .branch_taken_i(branch),
    .stall_o(stall[2]), .flush_o(flush[2]), .fwd_a_o(fwd_a[2]), .fwd_b_o(fwd_b[2]),
    .rf_byp_a_o(byp_a[2]), .rf_byp_b_o(byp_b[2]), .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2));

  // Model: each DUT's in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit v; int rd; bit rw; bit mr; int rs; int rt; bit urs; bit urt;
  } ent_t;
  ent_t   pipe [3][3];
  longint scnt_m [3];
  longint fcnt_m [3];
  int     fwd_en_m [3] = '{1, 0, 1};
  longint cmax_m [3]   = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};

  function automatic bit wr(ent_t e, int r);
    return e.v && e.rw && e.rd == r && r != 0;
  endfunction

  function automatic bit needs(int d, int k);
    return (id_use_rs && wr(pipe[d][k], int'(id_rs))) || (id_use_rt && wr(pipe[d][k], int'(id_rt)));
  endfunction

  function automatic bit m_stall(int d);
    bit haz = 0;
    if (rst || branch || !id_valid) return 0;
    if (fwd_en_m[d] != 0) return pipe[d][0].mr && needs(d, 0);
    for (int k = 0; k < 3; k++) if (needs(d, k)) haz = 1;
    return haz;
  endfunction

  function automatic logic [1:0] m_fwd(int d, bit b);
    ent_t ex = pipe[d][0];
    int r;
    if (rst || fwd_en_m[d] == 0 || !ex.v) return 2'd0;
    if (b ? !ex.urt : !ex.urs) return 2'd0;
    r = b ? ex.rt : ex.rs;
    if (wr(pipe[d][1], r) && !pipe[d][1].mr) return 2'd2;
    if (wr(pipe[d][2], r)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit m_byp(int d, bit b);
    if (rst) return 0;
    return b ? (id_use_rt && wr(pipe[d][2], int'(id_rt))) : (id_use_rs && wr(pipe[d][2], int'(id_rs)));
  endfunction

  task automatic m_edge();
    bit s;
    for (int d = 0; d < 3; d++) begin
      s = m_stall(d);
      if (rst) begin
        for (int k = 0; k < 3; k++) pipe[d][k].v = 0;
        scnt_m[d] = 0;
        fcnt_m[d] = 0;
      end else begin
        if (s && scnt_m[d] < cmax_m[d]) scnt_m[d]++;
        if (branch && fcnt_m[d] < cmax_m[d]) fcnt_m[d]++;
        pipe[d][2] = pipe[d][1];
        pipe[d][1] = pipe[d][0];
        if (branch) pipe[d][1].v = 0;
        pipe[d][0] = '{v: id_valid && !s && !branch, rd: int'(id_rd), rw: id_reg_write,
                       mr: id_mem_read, rs: int'(id_rs), rt: int'(id_rt),
                       urs: id_use_rs, urt: id_use_rt};
      end
    end
  endtask

  function automatic longint got_cnt(int d, bit f);
    case (d)
      0:       return f ? longint'(fcnt0) : longint'(scnt0);
      1:       return f ? longint'(fcnt1) : longint'(scnt1);
      default: return f ? longint'(fcnt2) : longint'(scnt2);
    endcase
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      m_edge();
      mdl_ok = 1;
      @(negedge clk);
      if (mdl_ok && !done) begin
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("u%0d.stall", d), longint'(stall[d]), longint'(m_stall(d)));
          chk($sformatf("u%0d.flush", d), longint'(flush[d]), longint'(branch));
          chk($sformatf("u%0d.fwd_a", d), longint'(fwd_a[d]), longint'(m_fwd(d, 0)));
          chk($sformatf("u%0d.fwd_b", d), longint'(fwd_b[d]), longint'(m_fwd(d, 1)));
          chk($sformatf("u%0d.byp_a", d), longint'(byp_a[d]), longint'(m_byp(d, 0)));
          chk($sformatf("u%0d.byp_b", d), longint'(byp_b[d]), longint'(m_byp(d, 1)));
          chk($sformatf("u%0d.stall_cnt", d), got_cnt(d, 0), scnt_m[d]);
          chk($sformatf("u%0d.flush_cnt", d), got_cnt(d, 1), fcnt_m[d]);
        end
      end
    end
  end

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit rw, input bit mr);
    id_valid = v;   id_rs = rs[AW-1:0]; id_rt = rt[AW-1:0];
    id_use_rs = urs; id_use_rt = urt;   id_rd = rd[AW-1:0];
    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();                  set_id(0, 0, 0, 0, 0, 0, 0, 0);      endtask
  task automatic lw(int rd, int base);   set_id(1, base, 0, 1, 0, rd, 1, 1);  endtask
  task automatic alu(int rd, int rs, int rt); set_id(1, rs, rt, 1, 1, rd, 1, 0); endtask
  task automatic next(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  task automatic do_reset();
    next(); rst = 1; branch = 0; nop();
    next(); rst = 0;
  endtask

  initial begin
    rst = 1; branch = 0; nop();
    next();
    // During reset: flush follows the branch, nothing else asserts.
    branch = 1; alu(3, 0, 0); mid();
    chk("rst_flush", longint'(flush[0]), 1);
    chk("rst_stall", longint'(stall[0]), 0);
    chk("rst_fwd_a", longint'(fwd_a[0]), 0);
    next(); rst = 0; branch = 0; nop(); mid();
    chk("rst_scnt", longint'(scnt0), 0);
    chk("rst_fcnt", longint'(fcnt0), 0);

    // Load-use with forwarding: one stall, then WB forward.
    next(); lw(2, 1); mid();
    next(); alu(3, 2, 4); mid();
    chk("lu_stall", longint'(stall[0]), 1);
    chk("lu_stall_nofwd", longint'(stall[1]), 1);
    next(); mid();
    chk("lu_unstall", longint'(stall[0]), 0);
    chk("lu_scnt", longint'(scnt0), 1);
    next(); nop(); mid();
    chk("lu_fwd_a", longint'(fwd_a[0]), 1);
    do_reset();

    // ALU chain: back-to-back forwards from MEM, then from WB.
    next(); alu(2, 1, 1); mid();
    next(); alu(5, 2, 2); mid();
    chk("alu_nostall", longint'(stall[0]), 0);
    next(); nop(); mid();
    chk("alu_fwd_a_mem", longint'(fwd_a[0]), 2);
    chk("alu_fwd_b_mem", longint'(fwd_b[0]), 2);
    next(); alu(2, 1, 1); mid();
    next(); alu(9, 10, 11); mid();
    next(); alu(5, 2, 2); mid();
    chk("alu2_nostall", longint'(stall[0]), 0);
    chk("alu2_stall_nofwd", longint'(stall[1]), 1);
    next(); nop(); mid();
    chk("alu_fwd_a_wb", longint'(fwd_a[0]), 1);
    chk("alu_fwd_b_wb", longint'(fwd_b[0]), 1);
    do_reset();

    // No forwarding: RAW stalls three cycles until writeback.
    next(); alu(2, 7, 8); mid();
    next(); alu(6, 2, 0); mid();
    chk("nf_stall1", longint'(stall[1]), 1);
    next(); mid();
    chk("nf_stall2", longint'(stall[1]), 1);
    next(); mid();
    chk("nf_stall3", longint'(stall[1]), 1);
    chk("nf_byp_a", longint'(byp_a[1]), 1);
    next(); mid();
    chk("nf_release", longint'(stall[1]), 0);
    chk("nf_scnt", longint'(scnt1), 3);
    next(); nop(); mid();
    do_reset();

    // Flush during a load-use hazard.
    next(); alu(2, 1, 1); mid();
    next(); lw(2, 1); mid();
    next(); alu(3, 2, 4); branch = 1; mid();
    chk("fl_flush", longint'(flush[0]), 1);
    chk("fl_stall", longint'(stall[0]), 0);
    chk("fl_stall_nofwd", longint'(stall[1]), 0);
    next(); nop(); branch = 0; mid();
    chk("fl_fwd_a", longint'(fwd_a[0]), 0);
    chk("fl_fwd_b", longint'(fwd_b[0]), 0);
    chk("fl_fcnt", longint'(fcnt0), 1);
    do_reset();

    // Register 0 never creates a dependency.
    next(); lw(0, 1); mid();
    next(); alu(3, 0, 0); mid();
    chk("r0_stall", longint'(stall[0]), 0);
    chk("r0_stall_nofwd", longint'(stall[1]), 0);
    next(); nop(); mid();
    chk("r0_fwd_a", longint'(fwd_a[0]), 0);
    next(); alu(1, 0, 0); mid();
    chk("r0_byp_a", longint'(byp_a[0]), 0);
    chk("r0_byp_b", longint'(byp_b[0]), 0);
    chk("r0_byp_a_nofwd", longint'(byp_a[1]), 0);
    do_reset();

    // Counter saturation, then reset with a load in EX.
    for (int i = 0; i < 5; i++) begin
      next(); lw(2, 1); mid();
      next(); alu(3, 2, 4); mid();
      chk($sformatf("sat_stall%0d", i), longint'(stall[2]), 1);
    end
    next(); lw(2, 1); mid();
    chk("sat_scnt2", longint'(scnt2), 3);
    chk("sat_scnt0", longint'(scnt0), 5);
    next(); alu(3, 2, 4); rst = 1; mid();
    chk("rstld_stall", longint'(stall[0]), 0);
    next(); rst = 0; mid();
    chk("post_rst_stall", longint'(stall[2]), 0);
    chk("post_rst_scnt2", longint'(scnt2), 0);
    chk("post_rst_fcnt2", longint'(fcnt2), 0);
    next(); nop(); mid();

    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
